// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_pkg : 640x480@60 VGA timing constants and pipeline stage type         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package vga_pkg;

  localparam logic [9:0] c_h_active = 10'd640;
  localparam logic [9:0] c_h_fp     = 10'd16;
  localparam logic [9:0] c_h_sync   = 10'd96;
  localparam logic [9:0] c_h_bp     = 10'd48;
  localparam logic [9:0] c_h_total  = c_h_active + c_h_fp + c_h_sync + c_h_bp;

  localparam logic [9:0] c_v_active = 10'd480;
  localparam logic [9:0] c_v_fp     = 10'd10;
  localparam logic [9:0] c_v_sync   = 10'd2;
  localparam logic [9:0] c_v_bp     = 10'd33;
  localparam logic [9:0] c_v_total  = c_v_active + c_v_fp + c_v_sync + c_v_bp;

  localparam logic [9:0] c_h_sync_start = c_h_active + c_h_fp;
  localparam logic [9:0] c_h_sync_end   = c_h_sync_start + c_h_sync;
  localparam logic [9:0] c_v_sync_start = c_v_active + c_v_fp;
  localparam logic [9:0] c_v_sync_end   = c_v_sync_start + c_v_sync;
  localparam logic [9:0] c_h_last       = c_h_total - 10'd1;
  localparam logic [9:0] c_v_last       = c_v_total - 10'd1;
  localparam logic [9:0] c_v_last_act   = c_v_active - 10'd1;

  // Per-pixel side-band carried alongside the memory fetch.
  typedef struct packed {
    logic in_img;
    logic hs;
    logic vs;
  } stage_t;

  localparam stage_t c_stage_idle = '{in_img: 1'b0, hs: 1'b1, vs: 1'b1};

  function automatic logic in_window(input logic [9:0] x,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing : free-running H/V counters with active-low sync decode        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hs,
  output logic       vs
);

  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic       w_h_wrap;
  logic       w_v_wrap;

  assign w_h_wrap = (r_hc == c_h_last);
  assign w_v_wrap = (r_vc == c_v_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_h_wrap) begin
      r_hc <= '0;
      r_vc <= w_v_wrap ? '0 : r_vc + 10'd1;
    end else begin
      r_hc <= r_hc + 10'd1;
    end
  end

  assign hc = r_hc;
  assign vc = r_vc;
  assign hs = !in_window(r_hc, c_h_sync_start, c_h_sync_end);
  assign vs = !in_window(r_vc, c_v_sync_start, c_v_sync_end);

endmodule
`default_nettype wire

// File: rtl/vga_frame_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_frame_reader : streams a greyscale frame from memory to VGA RGB       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int          IMG_W     = 256,
  parameter int          IMG_H     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        image_select,
  input  logic [7:0]  encrypted_gpu,
  input  logic [7:0]  decrypted_gpu,
  output logic [31:0] gpu_address,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] rgb_out,
  output logic        frame_done
);

  localparam logic [31:0] c_img_w = 32'(IMG_W);
  localparam logic [31:0] c_img_h = 32'(IMG_H);

  logic [9:0]  w_hc;
  logic [9:0]  w_vc;
  logic        w_hs;
  logic        w_vs;
  logic        w_frame_start;
  stage_t      w_s0;
  logic [31:0] w_addr;
  logic [7:0]  w_pix;

  stage_t      r_s1;
  logic        r_frame_sel;
  logic [31:0] r_addr;
  logic [23:0] r_rgb;
  logic        r_hsync;
  logic        r_vsync;

  vga_timing u_timing (
    .clk   (clk),
    .reset (reset),
    .hc    (w_hc),
    .vc    (w_vc),
    .hs    (w_hs),
    .vs    (w_vs)
  );

  always_comb begin
    w_s0.in_img   = ({22'd0, w_hc} < c_img_w) && ({22'd0, w_vc} < c_img_h);
    w_s0.hs       = w_hs;
    w_s0.vs       = w_vs;
    w_addr        = BASE_ADDR + ({22'd0, w_vc} * c_img_w) + {22'd0, w_hc};
    w_frame_start = (w_hc == 10'd0) && (w_vc == 10'd0);
    w_pix         = r_frame_sel ? decrypted_gpu : encrypted_gpu;
  end

  // Source is sampled once per frame so a frame never mixes two images.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_sel <= 1'b0;
    end else if (w_frame_start) begin
      r_frame_sel <= image_select;
    end
  end

  // Stage 1: issue fetch; address holds outside the image.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1   <= c_stage_idle;
      r_addr <= BASE_ADDR;
    end else begin
      r_s1 <= w_s0;
      if (w_s0.in_img) begin
        r_addr <= w_addr;
      end
    end
  end

  // Stage 2: memory byte is valid now, one cycle after the address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_rgb   <= r_s1.in_img ? {3{w_pix}} : 24'h0;
      r_hsync <= r_s1.hs;
      r_vsync <= r_s1.vs;
    end
  end

  assign gpu_address = r_addr;
  assign rgb_out     = r_rgb;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_done  = (w_hc == c_h_last) && (w_vc == c_v_last_act);

endmodule
`default_nettype wire

// File: doc/vga_frame_reader.md
VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameter IMG_W, default 256: image width in pixels.
REQ-002 Parameter IMG_H, default 256: image height in lines.
REQ-003 Parameter BASE_ADDR, default 32'h0: memory byte address of pixel (0,0).
REQ-004 Port clk, in, 1: pixel clock (25 MHz); single clock domain.
REQ-005 Port reset, in, 1: asynchronous, active-low reset.
REQ-006 Port image_select, in, 1: 0 selects the encrypted image, 1 selects the decrypted image.
REQ-007 Port encrypted_gpu, in, 8: encrypted byte at gpu_address, returned one cycle after the address.
REQ-008 Port decrypted_gpu, in, 8: decrypted byte at gpu_address, same one-cycle latency.
REQ-009 Port gpu_address, out, 32: pixel fetch address, registered.
REQ-010 Port hsync, out, 1: horizontal sync, active-low.
REQ-011 Port vsync, out, 1: vertical sync, active-low.
REQ-012 Port rgb_out, out, 24: {R,G,B}, grey byte replicated in all three.
REQ-013 Port frame_done, out, 1: one-cycle pulse at end of the last active line.

Function
REQ-014 Horizontal counter hc SHALL count 0..799 and wrap to 0: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-015 Vertical counter vc SHALL increment when hc wraps; it counts 0..524 and wraps to 0: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-016 Stage 0 (counters) SHALL compute in_img = (hc<IMG_W)&&(vc<IMG_H).
REQ-017 Stage 1 SHALL register gpu_address = BASE_ADDR + vc*IMG_W + hc when in_img; otherwise it holds its last value.
REQ-018 Stage 2 SHALL register rgb_out = {3{pix}} when the delayed in_img is 1, else 24'h0; pix is the byte chosen by frame_sel.
REQ-019 hsync and vsync SHALL be decoded at stage 0 and delayed 2 cycles so they stay aligned with rgb_out; total pixel latency is 2 cycles.
REQ-020 frame_sel SHALL latch image_select only at hc==0 && vc==0; a mid-frame image_select change takes effect at the next frame.
REQ-021 frame_done SHALL pulse for exactly 1 cycle at stage-0 position hc==799, vc==479.
REQ-022 Pixels outside the image but inside the active area SHALL be black; blanking SHALL always be black.
REQ-023 Address arithmetic SHALL be 32-bit unsigned; IMG_W and IMG_H are at most 640 and 480 respectively.

Reset
REQ-024 While reset==0: hc=0, vc=0, gpu_address=BASE_ADDR, rgb_out=0, hsync=1, vsync=1, frame_done=0, frame_sel=0, all pipeline registers 0.
REQ-025 Deassertion SHALL start a fresh frame at hc=0, vc=0; reset asserted mid-frame SHALL abort the frame immediately, with no frame_done.

Structure
REQ-026 The VGA timing constants (active, porch, sync and total for H and V) SHALL live in the shared package vga_pkg.
REQ-027 The counters and sync decode SHALL be one sub-module, vga_timing (outputs hc, vc, hs, vs); fetch and pipeline stay in the top level.

Verification
REQ-028 Release reset, run 800 cycles -> hsync low for exactly 96 cycles, first falling edge at cycle 656+2.
REQ-029 Run one full frame -> vsync low for exactly 2 lines (1600 cycles), frame period 420000 cycles, exactly one frame_done pulse.
REQ-030 Memory model returns byte = addr[7:0] with image_select=1, hc=5, vc=3 -> gpu_address = BASE_ADDR+773; two cycles after that counter position, rgb_out = 24'h050505.
REQ-031 Pixel at hc=300, vc=10 (outside 256x256) -> rgb_out = 0 and gpu_address unchanged.
REQ-032 Toggle image_select at vc=100 -> the rest of the frame keeps the old source; the next frame uses the new source.
REQ-033 Assert reset at vc=200 -> outputs reach reset values asynchronously; after release the counters restart at 0 and no frame_done occurs for the aborted frame.
